// File: rtl/reg_file_cc_if.sv
// Write-back handshake between the ALU result stage and the register file.
// The master presents a result; the slave (register file) returns ready.
interface reg_file_cc_if #(
   parameter int WIDTH = 16,
   parameter int AW    = 3
);
   logic             wb_valid;
   logic             wb_ready;
   logic [AW-1:0]    wb_dr;
   logic [WIDTH-1:0] wb_data;
   logic             wb_ld_cc;

   modport master (output wb_valid, wb_dr, wb_data, wb_ld_cc, input wb_ready);
   modport slave  (input wb_valid, wb_dr, wb_data, wb_ld_cc, output wb_ready);
endinterface

// File: rtl/reg_file_cc.sv
// Register file with a one-entry write-back pending stage, read bypass from
// the pending entry, and N/Z/P condition codes updated at commit.
module reg_file_cc #(
   parameter int WIDTH = 16,
   parameter int NREGS = 8,
   localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1
) (
   input  logic             clk,
   input  logic             reset,
   reg_file_cc_if.slave     wb,
   input  logic             stall,
   input  logic [AW-1:0]    sr1,
   input  logic [AW-1:0]    sr2,
   output logic [WIDTH-1:0] sr1_out,
   output logic [WIDTH-1:0] sr2_out,
   output logic [2:0]       nzp,
   output logic             pend_valid
);

   typedef enum logic {EMPTY = 1'b0, HELD = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [AW-1:0]    pend_dr_q, pend_dr_d;
   logic [WIDTH-1:0] pend_data_q, pend_data_d;
   logic             pend_ld_cc_q, pend_ld_cc_d;
   logic [2:0]       nzp_q, nzp_d;
   logic [WIDTH-1:0] regs_q [NREGS];
   logic [WIDTH-1:0] regs_d [NREGS];

   logic accept;
   logic commit;
   logic pend_in_range;

   assign pend_valid    = (state_q == HELD);
   assign nzp           = nzp_q;
   assign pend_in_range = (int'(pend_dr_q) < NREGS);

   // Pending-stage control, commit into the array and condition-code update.
   always_comb begin
      state_d      = state_q;
      pend_dr_d    = pend_dr_q;
      pend_data_d  = pend_data_q;
      pend_ld_cc_d = pend_ld_cc_q;
      nzp_d        = nzp_q;
      regs_d       = regs_q;

      wb.wb_ready = !(pend_valid && stall);
      accept      = wb.wb_valid && wb.wb_ready;
      commit      = pend_valid && !stall;

      if (commit) begin
         if (pend_in_range) begin
            regs_d[pend_dr_q] = pend_data_q;
         end
         if (pend_ld_cc_q) begin
            if (pend_data_q[WIDTH-1]) begin
               nzp_d = 3'b100;
            end else if (pend_data_q == '0) begin
               nzp_d = 3'b010;
            end else begin
               nzp_d = 3'b001;
            end
         end
      end

      case (state_q)
         EMPTY: if (accept) state_d = HELD;
         HELD:  if (!stall) state_d = accept ? HELD : EMPTY;
         default: state_d = EMPTY;
      endcase

      if (accept) begin
         pend_dr_d    = wb.wb_dr;
         pend_data_d  = wb.wb_data;
         pend_ld_cc_d = wb.wb_ld_cc;
      end
   end

   // Read ports: the held entry shadows the array; out-of-range indices read 0.
   always_comb begin
      sr1_out = '0;
      sr2_out = '0;
      if (pend_valid && pend_in_range && (sr1 == pend_dr_q)) begin
         sr1_out = pend_data_q;
      end else if (int'(sr1) < NREGS) begin
         sr1_out = regs_q[sr1];
      end
      if (pend_valid && pend_in_range && (sr2 == pend_dr_q)) begin
         sr2_out = pend_data_q;
      end else if (int'(sr2) < NREGS) begin
         sr2_out = regs_q[sr2];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= EMPTY;
         pend_dr_q    <= '0;
         pend_data_q  <= '0;
         pend_ld_cc_q <= 1'b0;
         nzp_q        <= 3'b010;
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         pend_dr_q    <= pend_dr_d;
         pend_data_q  <= pend_data_d;
         pend_ld_cc_q <= pend_ld_cc_d;
         nzp_q        <= nzp_d;
         regs_q       <= regs_d;
      end
   end

endmodule

// File: tb/tb_reg_file_cc.sv
// Scoreboard bench for reg_file_cc: directed scenarios plus random traffic,
// checked against an architectural model (array + pending queue).
module tb_reg_file_cc;

   logic        clk;
   logic        reset;
   logic        stall;
   logic [2:0]  sr1, sr2;
   logic [15:0] sr1_out, sr2_out;
   logic [2:0]  nzp;
   logic        pend_valid;

   reg_file_cc_if #(.WIDTH(16), .AW(3)) wb_if ();

   reg_file_cc #(.WIDTH(16), .NREGS(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .wb         (wb_if),
      .stall      (stall),
      .sr1        (sr1),
      .sr2        (sr2),
      .sr1_out    (sr1_out),
      .sr2_out    (sr2_out),
      .nzp        (nzp),
      .pend_valid (pend_valid)
   );

   typedef struct {
      logic        ready;
      logic        pv;
      logic [2:0]  cc;
      logic [15:0] s1;
      logic [15:0] s2;
   } exp_t;

   typedef struct {
      logic [2:0]  dr;
      logic [15:0] data;
      logic        ld;
   } pend_t;

   exp_t        exp_q[$];
   pend_t       m_pend[$];
   logic [15:0] m_arr [8];
   logic [2:0]  m_nzp;
   int          n_compared;
   int          n_mismatched;
   exp_t        mon_e;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [2:0] ccOf(input logic [15:0] d);
      if (d == 16'd0)          return 3'b010;
      else if (d >= 16'h8000)  return 3'b100;
      else                     return 3'b001;
   endfunction

   function automatic logic [15:0] modelRead(input logic [2:0] idx);
      if (m_pend.size() > 0 && m_pend[0].dr == idx) return m_pend[0].data;
      return m_arr[idx];
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 8; i++) m_arr[i] = 16'd0;
      m_pend.delete();
      m_nzp = 3'b010;
   endtask

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] expv);
      n_compared++;
      if (act !== expv) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   // One cycle: drive at negedge, queue the expected outputs, advance model at posedge.
   task automatic applyStimulus(input logic rst, input logic v, input logic [2:0] dr,
                                input logic [15:0] data, input logic ld, input logic st,
                                input logic [2:0] s1, input logic [2:0] s2);
      exp_t  e;
      pend_t p;
      logic  accepted;
      @(negedge clk);
      reset          = rst;
      wb_if.wb_valid = v;
      wb_if.wb_dr    = dr;
      wb_if.wb_data  = data;
      wb_if.wb_ld_cc = ld;
      stall          = st;
      sr1            = s1;
      sr2            = s2;
      e.ready  = !(m_pend.size() > 0 && st);
      e.pv     = (m_pend.size() > 0);
      e.cc     = m_nzp;
      e.s1     = modelRead(s1);
      e.s2     = modelRead(s2);
      exp_q.push_back(e);
      accepted = v && e.ready;
      @(posedge clk);
      if (rst) begin
         modelReset();
      end else begin
         if (m_pend.size() > 0 && !st) begin
            p = m_pend.pop_front();
            m_arr[p.dr] = p.data;
            if (p.ld) m_nzp = ccOf(p.data);
         end
         if (accepted) begin
            p.dr = dr; p.data = data; p.ld = ld;
            m_pend.push_back(p);
         end
      end
   endtask

   task automatic idle(input logic [2:0] s1, input logic [2:0] s2);
      applyStimulus(1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0, s1, s2);
   endtask

   // Monitor: compares the DUT outputs for every queued cycle, mid-low-phase.
   always @(negedge clk) begin
      #2;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         checkOutput("wb_ready",   {15'd0, wb_if.wb_ready}, {15'd0, mon_e.ready});
         checkOutput("pend_valid", {15'd0, pend_valid},     {15'd0, mon_e.pv});
         checkOutput("nzp",        {13'd0, nzp},            {13'd0, mon_e.cc});
         checkOutput("sr1_out",    sr1_out,                 mon_e.s1);
         checkOutput("sr2_out",    sr2_out,                 mon_e.s2);
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int waited;
      logic [15:0] rdata;
      n_compared   = 0;
      n_mismatched = 0;
      reset = 1'b1; stall = 1'b0; sr1 = 3'd0; sr2 = 3'd0;
      wb_if.wb_valid = 1'b0; wb_if.wb_dr = 3'd0; wb_if.wb_data = 16'd0; wb_if.wb_ld_cc = 1'b0;
      modelReset();
      @(posedge clk);
      @(posedge clk);

      // Reset state, all indices on both ports; a request during reset is dropped.
      applyStimulus(1'b1, 1'b1, 3'd1, 16'h5555, 1'b1, 1'b0, 3'd1, 3'd1);
      for (int i = 0; i < 8; i++) idle(i[2:0], 3'(7 - i));

      // Write with bypass then commit, nzp negative.
      applyStimulus(1'b0, 1'b1, 3'd3, 16'h8001, 1'b1, 1'b0, 3'd3, 3'd0);
      idle(3'd3, 3'd3);
      idle(3'd3, 3'd0);

      // Back-to-back writes to the same register.
      applyStimulus(1'b0, 1'b1, 3'd5, 16'h0000, 1'b1, 1'b0, 3'd5, 3'd3);
      applyStimulus(1'b0, 1'b1, 3'd5, 16'h0042, 1'b0, 1'b0, 3'd5, 3'd5);
      idle(3'd5, 3'd5);
      idle(3'd5, 3'd0);

      // Held entry under stall; a competing request must not be taken.
      applyStimulus(1'b0, 1'b1, 3'd2, 16'h1234, 1'b1, 1'b0, 3'd2, 3'd2);
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b0, 1'b1, 3'd2, 16'hDEAD, 1'b1, 1'b1, 3'd1, 3'd2);
      idle(3'd2, 3'd2);
      idle(3'd2, 3'd2);

      // Reset coinciding with stall release discards the held entry.
      applyStimulus(1'b0, 1'b1, 3'd4, 16'h7777, 1'b1, 1'b0, 3'd4, 3'd4);
      applyStimulus(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'd4, 3'd4);
      applyStimulus(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd4, 3'd4);
      idle(3'd4, 3'd4);

      // Dual-port bypass on the same index.
      applyStimulus(1'b0, 1'b1, 3'd6, 16'h0ABC, 1'b1, 1'b0, 3'd6, 3'd7);
      applyStimulus(1'b0, 1'b1, 3'd7, 16'hFFFF, 1'b1, 1'b0, 3'd7, 3'd7);
      idle(3'd7, 3'd7);
      idle(3'd6, 3'd7);

      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 3))
            0:       rdata = 16'd0;
            1:       rdata = 16'h8000 | 16'($urandom);
            default: rdata = 16'($urandom);
         endcase
         applyStimulus(($urandom_range(0, 99) < 2),
                       ($urandom_range(0, 99) < 70),
                       3'($urandom), rdata, 1'($urandom),
                       ($urandom_range(0, 99) < 30),
                       3'($urandom), 3'($urandom));
      end
      idle(3'd0, 3'd1);

      waited = 0;
      while (exp_q.size() > 0 && waited < 10) begin
         @(negedge clk);
         #3;
         waited++;
      end
      if (exp_q.size() > 0) begin
         n_compared++;
         n_mismatched++;
         $display("[TB] FAIL drain: got %0d unchecked cycles expected 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
